// File: rtl/eth_sd_blk_sched.sv
// ---------------------------------------------------------------------------
// eth_sd_blk_sched
//
// Moves data from a prefetch FIFO into an SD card block-write engine, one
// block of BLK_WORDS words at a time, for a requested number of blocks.
// For each block it requests a write, streams the words through with zero
// latency, then waits for the engine to report the block as programmed.
// A transfer can be aborted at any point; the done pulse then carries err=1.
//
// Ports
//   clk_i, rst_ni         single clock, asynchronous active-low reset
//   start_i, blk_num_i    begin a transfer of blk_num_i blocks (IDLE only)
//   abort_i               terminate the current transfer
//   busy_o, done_o, err_o transfer status; err_o is valid with done_o
//   blk_cnt_o             blocks completed in the current or last transfer
//   fifo_rd_*             prefetch FIFO read port (pop on en & vld)
//   sd_wr_req_o/ack_i     per-block write request handshake
//   sd_data*/sd_last_o    block data stream to the SD engine
//   sd_blk_done_i         engine finished programming the block
// ---------------------------------------------------------------------------
module eth_sd_blk_sched #(
    parameter int DATA_W    = 32,
    parameter int BLK_WORDS = 128,
    parameter int BLK_CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [BLK_CNT_W-1:0] blk_num_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [BLK_CNT_W-1:0] blk_cnt_o,
    output logic                 fifo_rd_en_o,
    input  logic                 fifo_rd_vld_i,
    input  logic [DATA_W-1:0]    fifo_rd_data_i,
    output logic                 sd_wr_req_o,
    input  logic                 sd_wr_ack_i,
    output logic [DATA_W-1:0]    sd_data_o,
    output logic                 sd_data_vld_o,
    input  logic                 sd_data_rdy_i,
    output logic                 sd_last_o,
    input  logic                 sd_blk_done_i
);

    localparam int WORD_W = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(BLK_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_WAIT_DONE,
        S_FIN
    } state_e;

    state_e               state_q;
    logic [BLK_CNT_W-1:0] blk_num_q;
    logic [BLK_CNT_W-1:0] blk_cnt_q;
    logic [BLK_CNT_W-1:0] blk_cnt_d;
    logic [WORD_W-1:0]    word_cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;
    logic                 sd_wr_req_q;
    logic                 in_xfer;
    logic                 beat;
    logic                 abortable;

    assign in_xfer   = (state_q == S_XFER);
    assign blk_cnt_d = blk_cnt_q + 1'b1;

    // abort suppresses the pop in the same cycle, so a word is never lost
    // from the FIFO without reaching the SD engine.
    assign beat      = in_xfer & fifo_rd_vld_i & sd_data_rdy_i & ~abort_i;
    assign abortable = (state_q == S_REQ) || (state_q == S_XFER) ||
                       (state_q == S_WAIT_DONE);

    // Data path is a straight pass-through while streaming a block.
    assign fifo_rd_en_o  = in_xfer & sd_data_rdy_i & ~abort_i;
    assign sd_data_vld_o = in_xfer & fifo_rd_vld_i;
    assign sd_data_o     = in_xfer ? fifo_rd_data_i : '0;
    assign sd_last_o     = in_xfer & (word_cnt_q == LAST_WORD);

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign blk_cnt_o   = blk_cnt_q;
    assign sd_wr_req_o = sd_wr_req_q;

    // Status outputs are registered alongside the state so that done_q is
    // high exactly while in FIN and sd_wr_req_q exactly while in REQ.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            blk_num_q   <= '0;
            blk_cnt_q   <= '0;
            word_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            sd_wr_req_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_i && abortable) begin
                state_q     <= S_FIN;
                word_cnt_q  <= '0;
                sd_wr_req_q <= 1'b0;
                done_q      <= 1'b1;
                err_q       <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            blk_num_q  <= blk_num_i;
                            blk_cnt_q  <= '0;
                            word_cnt_q <= '0;
                            err_q      <= 1'b0;
                            busy_q     <= 1'b1;
                            if (blk_num_i == '0) begin
                                state_q <= S_FIN;
                                done_q  <= 1'b1;
                            end else begin
                                state_q     <= S_REQ;
                                sd_wr_req_q <= 1'b1;
                            end
                        end
                    end
                    S_REQ: begin
                        if (sd_wr_ack_i) begin
                            state_q     <= S_XFER;
                            sd_wr_req_q <= 1'b0;
                        end
                    end
                    S_XFER: begin
                        if (beat) begin
                            if (word_cnt_q == LAST_WORD) begin
                                word_cnt_q <= '0;
                                state_q    <= S_WAIT_DONE;
                            end else begin
                                word_cnt_q <= word_cnt_q + 1'b1;
                            end
                        end
                    end
                    S_WAIT_DONE: begin
                        if (sd_blk_done_i) begin
                            blk_cnt_q <= blk_cnt_d;
                            if (blk_cnt_d < blk_num_q) begin
                                state_q     <= S_REQ;
                                sd_wr_req_q <= 1'b1;
                            end else begin
                                state_q <= S_FIN;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    S_FIN: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        sd_wr_req_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eth_sd_blk_sched.sv
// ---------------------------------------------------------------------------
// tb_eth_sd_blk_sched
//
// Scoreboard bench for eth_sd_blk_sched. Each transfer pushes its expected
// SD beats (data + last flag) and its expected done status into queues; a
// negedge monitor pops and compares whenever the DUT produces a beat or a
// done pulse. A responder process models the FIFO (incrementing data
// pattern), the SD ack, and sd_blk_done three cycles after each last beat.
// ---------------------------------------------------------------------------
module tb_eth_sd_blk_sched;

    localparam int DATA_W    = 32;
    localparam int BLK_WORDS = 128;
    localparam int BLK_CNT_W = 16;
    localparam logic [31:0] DATA_BASE = 32'hC0DE_0000;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic        err;
        logic [15:0] cnt;
    } done_t;

    logic                 clk;
    logic                 rstN;
    logic                 start;
    logic [BLK_CNT_W-1:0] blkNum;
    logic                 abort;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [BLK_CNT_W-1:0] blkCnt;
    logic                 fifoRdEn;
    logic                 fifoRdVld;
    logic [DATA_W-1:0]    fifoRdData;
    logic                 sdWrReq;
    logic                 sdWrAck;
    logic [DATA_W-1:0]    sdData;
    logic                 sdDataVld;
    logic                 sdDataRdy;
    logic                 sdLast;
    logic                 sdBlkDone;

    beat_t beatQ[$];
    done_t doneQ[$];

    int testsRun    = 0;
    int testsFailed = 0;
    int beatCount   = 0;
    int popCount    = 0;
    int lastCount   = 0;
    int reqHsCount  = 0;
    int reqCycCount = 0;
    int rdEnCount   = 0;
    int doneCount   = 0;
    int fifoIdx     = 0;
    int expIdx      = 0;
    int doneTimer   = 0;

    logic popThisCycle  = 1'b0;
    logic lastThisCycle = 1'b0;
    logic stallMode     = 1'b0;
    logic strayDone     = 1'b0;
    logic beatNow;
    beat_t expBeat;
    done_t expDone;

    eth_sd_blk_sched #(
        .DATA_W   (DATA_W),
        .BLK_WORDS(BLK_WORDS),
        .BLK_CNT_W(BLK_CNT_W)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .start_i       (start),
        .blk_num_i     (blkNum),
        .abort_i       (abort),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err),
        .blk_cnt_o     (blkCnt),
        .fifo_rd_en_o  (fifoRdEn),
        .fifo_rd_vld_i (fifoRdVld),
        .fifo_rd_data_i(fifoRdData),
        .sd_wr_req_o   (sdWrReq),
        .sd_wr_ack_i   (sdWrAck),
        .sd_data_o     (sdData),
        .sd_data_vld_o (sdDataVld),
        .sd_data_rdy_i (sdDataRdy),
        .sd_last_o     (sdLast),
        .sd_blk_done_i (sdBlkDone)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Queue the expected beats and done status, then pulse start for one cycle.
    task automatic applyStimulus(input logic [15:0] n, input int expBeats,
                                 input logic expErr, input logic [15:0] expCnt);
        for (int i = 0; i < expBeats; i++) begin
            beatQ.push_back(beat_t'{DATA_BASE + 32'(expIdx),
                                    ((i % BLK_WORDS) == (BLK_WORDS - 1))});
            expIdx++;
        end
        doneQ.push_back(done_t'{expErr, expCnt});
        @(posedge clk); #2;
        blkNum = n;
        start  = 1'b1;
        @(posedge clk); #2;
        start  = 1'b0;
    endtask

    task automatic pulseStart(input logic [15:0] n);
        blkNum = n;
        start  = 1'b1;
        @(posedge clk); #2;
        start  = 1'b0;
    endtask

    task automatic waitBeats(input int base, input int n, input string name);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            if (beatCount - base >= n) break;
        end
        checkOutput({name, " beats reached"}, 64'(beatCount - base), 64'(n));
    endtask

    task automatic waitDone(input int budget, input string name);
        int startDone;
        startDone = doneCount;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (doneCount != startDone) break;
        end
        checkOutput({name, " done pulses"}, 64'(doneCount - startDone), 64'd1);
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic checkQueuesEmpty(input string name);
        checkOutput({name, " beats left"}, 64'(beatQ.size()), 64'd0);
        checkOutput({name, " dones left"}, 64'(doneQ.size()), 64'd0);
    endtask

    // FIFO / SD engine responder: updates its outputs just after each edge.
    initial begin
        fifoRdVld  = 1'b0;
        fifoRdData = '0;
        sdDataRdy  = 1'b0;
        sdWrAck    = 1'b0;
        sdBlkDone  = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (popThisCycle) fifoIdx++;
            fifoRdVld  = stallMode ? ($urandom_range(0, 3) != 0) : 1'b1;
            sdDataRdy  = stallMode ? ($urandom_range(0, 2) != 0) : 1'b1;
            fifoRdData = DATA_BASE + 32'(fifoIdx);
            sdWrAck    = sdWrReq;
            if (lastThisCycle) doneTimer = 3;
            sdBlkDone = strayDone;
            if (doneTimer > 0) begin
                doneTimer--;
                if (doneTimer == 0) sdBlkDone = 1'b1;
            end
        end
    end

    // Monitor: pops expected beats/done status as the DUT presents them.
    initial begin
        forever begin
            @(negedge clk);
            beatNow       = sdDataVld && sdDataRdy && !abort;
            popThisCycle  = fifoRdEn && fifoRdVld;
            lastThisCycle = beatNow && sdLast;
            if (fifoRdEn) rdEnCount++;
            if (sdWrReq) reqCycCount++;
            if (sdWrReq && sdWrAck) reqHsCount++;
            if (popThisCycle) popCount++;
            if (popThisCycle || beatNow)
                checkOutput("pop matches beat", 64'(popThisCycle), 64'(beatNow));
            if (beatNow) begin
                beatCount++;
                if (sdLast) lastCount++;
                if (beatQ.size() == 0) begin
                    checkOutput("beat expected", 64'(beatQ.size()), 64'd1);
                end else begin
                    expBeat = beatQ.pop_front();
                    checkOutput("beat data", 64'(sdData), 64'(expBeat.data));
                    checkOutput("beat last", 64'(sdLast), 64'(expBeat.last));
                end
            end
            if (done) begin
                doneCount++;
                if (doneQ.size() == 0) begin
                    checkOutput("done expected", 64'(doneQ.size()), 64'd1);
                end else begin
                    expDone = doneQ.pop_front();
                    checkOutput("done err", 64'(err), 64'(expDone.err));
                    checkOutput("done blk_cnt", 64'(blkCnt), 64'(expDone.cnt));
                    checkOutput("done busy", 64'(busy), 64'd1);
                end
            end
        end
    end

    initial begin
        int bBeat;
        int bPop;
        int bLast;
        int bHs;
        int bReq;
        int bRdEn;
        int bDone;
        logic doneEarly;

        rstN   = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        blkNum = '0;

        // Reset state with the FIFO and SD side both asserting valid/ready.
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset err", 64'(err), 64'd0);
        checkOutput("reset blk_cnt", 64'(blkCnt), 64'd0);
        checkOutput("reset fifo_rd_en", 64'(fifoRdEn), 64'd0);
        checkOutput("reset sd_wr_req", 64'(sdWrReq), 64'd0);
        checkOutput("reset sd_data_vld", 64'(sdDataVld), 64'd0);
        checkOutput("reset sd_last", 64'(sdLast), 64'd0);
        @(posedge clk); #2;
        rstN = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // Two full blocks, no stalls.
        bBeat = beatCount; bPop = popCount; bLast = lastCount; bHs = reqHsCount;
        applyStimulus(16'd2, 2 * BLK_WORDS, 1'b0, 16'd2);
        waitDone(1500, "two blocks");
        checkOutput("two blocks beats", 64'(beatCount - bBeat), 64'd256);
        checkOutput("two blocks pops", 64'(popCount - bPop), 64'd256);
        checkOutput("two blocks lasts", 64'(lastCount - bLast), 64'd2);
        checkOutput("two blocks handshakes", 64'(reqHsCount - bHs), 64'd2);
        checkOutput("two blocks blk_cnt held", 64'(blkCnt), 64'd2);
        checkOutput("two blocks err held", 64'(err), 64'd0);
        checkOutput("two blocks idle", 64'(busy), 64'd0);
        checkQueuesEmpty("two blocks");

        // One block with random stalls on both sides.
        stallMode = 1'b1;
        bBeat = beatCount; bPop = popCount; bLast = lastCount;
        applyStimulus(16'd1, BLK_WORDS, 1'b0, 16'd1);
        waitDone(4000, "stalled block");
        stallMode = 1'b0;
        checkOutput("stalled beats", 64'(beatCount - bBeat), 64'd128);
        checkOutput("stalled pops", 64'(popCount - bPop), 64'd128);
        checkOutput("stalled lasts", 64'(lastCount - bLast), 64'd1);
        checkQueuesEmpty("stalled block");
        repeat (2) @(posedge clk);
        #2;

        // Zero-block request completes immediately without touching SD/FIFO.
        bReq = reqCycCount; bRdEn = rdEnCount;
        doneQ.push_back(done_t'{1'b0, 16'd0});
        blkNum = 16'd0;
        start  = 1'b1;
        @(negedge clk); #1;
        doneEarly = done;
        @(posedge clk); #2;
        start = 1'b0;
        @(negedge clk); #1;
        checkOutput("zero blk no early done", 64'(doneEarly), 64'd0);
        checkOutput("zero blk done at 2", 64'(done), 64'd1);
        checkOutput("zero blk err", 64'(err), 64'd0);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("zero blk no sd_wr_req", 64'(reqCycCount - bReq), 64'd0);
        checkOutput("zero blk no fifo_rd_en", 64'(rdEnCount - bRdEn), 64'd0);
        checkQueuesEmpty("zero blk");

        // Abort on what would be beat 50 of the first block.
        bBeat = beatCount; bPop = popCount;
        applyStimulus(16'd2, 49, 1'b1, 16'd0);
        waitBeats(bBeat, 49, "abort");
        abort = 1'b1;
        @(negedge clk); #1;
        checkOutput("abort fifo_rd_en forced", 64'(fifoRdEn), 64'd0);
        @(posedge clk); #2;
        abort = 1'b0;
        @(negedge clk); #1;
        checkOutput("abort done next cycle", 64'(done), 64'd1);
        checkOutput("abort err", 64'(err), 64'd1);
        checkOutput("abort blk_cnt", 64'(blkCnt), 64'd0);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("abort pops", 64'(popCount - bPop), 64'd49);
        checkOutput("abort err held", 64'(err), 64'd1);
        checkOutput("abort idle", 64'(busy), 64'd0);
        checkQueuesEmpty("abort");

        // start pulses while busy and a stray sd_blk_done mid-block.
        bBeat = beatCount;
        applyStimulus(16'd1, BLK_WORDS, 1'b0, 16'd1);
        waitBeats(bBeat, 5, "ignore start");
        pulseStart(16'd5);
        waitBeats(bBeat, 10, "stray done");
        strayDone = 1'b1;
        @(posedge clk); #2;
        strayDone = 1'b0;
        waitBeats(bBeat, 60, "ignore start 2");
        pulseStart(16'd7);
        checkOutput("stray done blk_cnt", 64'(blkCnt), 64'd0);
        checkOutput("stray done busy", 64'(busy), 64'd1);
        waitDone(1000, "ignore start");
        checkOutput("ignore start beats", 64'(beatCount - bBeat), 64'd128);
        checkOutput("ignore start blk_cnt", 64'(blkCnt), 64'd1);
        checkOutput("ignore start err cleared", 64'(err), 64'd0);
        checkOutput("ignore start idle", 64'(busy), 64'd0);
        checkQueuesEmpty("ignore start");

        // Reset mid-block, then a fresh transfer.
        bBeat = beatCount; bDone = doneCount;
        applyStimulus(16'd1, BLK_WORDS, 1'b0, 16'd1);
        waitBeats(bBeat, 20, "reset mid");
        rstN = 1'b0;
        #1;
        checkOutput("mid reset busy", 64'(busy), 64'd0);
        checkOutput("mid reset fifo_rd_en", 64'(fifoRdEn), 64'd0);
        checkOutput("mid reset sd_data_vld", 64'(sdDataVld), 64'd0);
        checkOutput("mid reset sd_last", 64'(sdLast), 64'd0);
        checkOutput("mid reset sd_wr_req", 64'(sdWrReq), 64'd0);
        checkOutput("mid reset done", 64'(done), 64'd0);
        checkOutput("mid reset blk_cnt", 64'(blkCnt), 64'd0);
        beatQ.delete();
        doneQ.delete();
        repeat (3) @(posedge clk);
        #2;
        rstN = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("mid reset no done", 64'(doneCount - bDone), 64'd0);
        expIdx = fifoIdx;
        bBeat = beatCount; bLast = lastCount;
        applyStimulus(16'd1, BLK_WORDS, 1'b0, 16'd1);
        waitDone(1000, "after reset");
        checkOutput("after reset beats", 64'(beatCount - bBeat), 64'd128);
        checkOutput("after reset lasts", 64'(lastCount - bLast), 64'd1);
        checkQueuesEmpty("after reset");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
